step_move_controller: RTL and testbench

- Sequences the stepper position datapath.
- Accepts move commands (direction, step count, step period) over a valid/ready handshake and generates evenly spaced internal steps.
- Alternatively yields control to the external step/dir pins when ext_ctrl is high.
- Owns the step position counter; a downstream full-step waveform decoder consumes step_pos[1:0].

---
 rtl/step_move_controller_pkg.sv | 9 +
 rtl/step_input_sync.sv | 23 ++
 rtl/step_move_controller.sv | 119 +++++++++++
 tb/tb_step_move_controller.sv | 139 +++++++++++++
 4 files changed

// File: rtl/step_move_controller_pkg.sv
// step_move_controller_pkg: shared state encoding, direction codes and default widths
package step_move_controller_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_POS_W = 32;
  localparam int DEF_MIN_PERIOD = 4;
endpackage

// File: rtl/step_input_sync.sv
// step_input_sync: synchronises external step/dir pins and flags step rising edges
module step_input_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_step,
  input  logic ext_dir,
  output logic step_edge,
  output logic dir_sync
);
  logic [2:0] s;
  logic [1:0] d;
  // two synchroniser stages plus one history stage for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s <= '0;
      d <= '0;
    end else begin
      s <= {s[1:0], ext_step};
      d <= {d[0], ext_dir};
    end
  assign step_edge = s[1] & ~s[2];
  assign dir_sync = d[1];
endmodule

// File: rtl/step_move_controller.sv
// step_move_controller: sequences timed internal moves or follows external step pins
module step_move_controller
  import step_move_controller_pkg::*;
#(
  parameter int POS_W = DEF_POS_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int DWELL_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_ctrl,
  input  logic             ext_step,
  input  logic             ext_dir,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0] cmd_period,
  input  logic             abort,
  input  logic             clear_pos,
  output logic [POS_W-1:0] step_pos,
  output logic             step_strobe,
  output logic             busy,
  output logic             done,
  output logic             aborted
);
  state_t state, state_n;
  logic dir, dir_n, done_n, aborted_n, int_step, ext_edge, ext_dir_s, step_any, step_neg;
  logic [CNT_W-1:0] remaining, remaining_n, period, period_n, timer, timer_n, dwell, dwell_n, req_period;
  step_input_sync u_sync (
    .clk(clk),
    .rst_n(rst_n),
    .ext_step(ext_step),
    .ext_dir(ext_dir),
    .step_edge(ext_edge),
    .dir_sync(ext_dir_s)
  );
  assign cmd_ready = (state == IDLE) & ~ext_ctrl;
  assign busy = state != IDLE;
  assign req_period = cmd_period < CNT_W'(MIN_PERIOD) ? CNT_W'(MIN_PERIOD) : cmd_period;
  assign step_any = (ext_ctrl & ext_edge) | int_step;
  assign step_neg = ext_ctrl ? ext_dir_s : dir;
  // next-state: accept commands, pace steps, dwell, and end early on abort or external takeover
  always_comb begin
    state_n = state;
    dir_n = dir;
    remaining_n = remaining;
    period_n = period;
    timer_n = timer;
    dwell_n = dwell;
    done_n = 1'b0;
    aborted_n = 1'b0;
    int_step = 1'b0;
    if (state != IDLE && (abort || ext_ctrl)) begin
      state_n = IDLE;
      done_n = 1'b1;
      aborted_n = 1'b1;
    end else
      case (state)
        IDLE: if (cmd_valid && cmd_ready) begin
          dir_n = cmd_dir;
          remaining_n = cmd_steps;
          period_n = req_period;
          timer_n = req_period - CNT_W'(1);
          done_n = cmd_steps == '0;
          state_n = cmd_steps == '0 ? IDLE : RUN;
        end
        RUN: if (timer == '0) begin
          int_step = 1'b1;
          remaining_n = remaining - CNT_W'(1);
          timer_n = period - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_n = DWELL_CYCLES == 0 ? IDLE : DWELL;
            done_n = DWELL_CYCLES == 0;
            dwell_n = CNT_W'(DWELL_CYCLES);
          end
        end else
          timer_n = timer - CNT_W'(1);
        DWELL: if (dwell <= CNT_W'(1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end else
          dwell_n = dwell - CNT_W'(1);
        default: state_n = IDLE;
      endcase
  end
  // sequencer state and completion pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= 1'b0;
      remaining <= '0;
      period <= '0;
      timer <= '0;
      dwell <= '0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state <= state_n;
      dir <= dir_n;
      remaining <= remaining_n;
      period <= period_n;
      timer <= timer_n;
      dwell <= dwell_n;
      done <= done_n;
      aborted <= aborted_n;
    end
  // position counter; clear wins over any coincident step, which is then dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step_pos <= '0;
      step_strobe <= 1'b0;
    end else begin
      step_strobe <= step_any & ~clear_pos;
      step_pos <= clear_pos ? '0 : !step_any ? step_pos :
                  step_neg == DIR_NEG ? step_pos - POS_W'(1) : step_pos + POS_W'(1);
    end
endmodule

// File: tb/tb_step_move_controller.sv
// tb_step_move_controller: directed and randomized checks against a timing-formula reference
module tb_step_move_controller;
  localparam int POS_W = 32;
  localparam int CNT_W = 16;
  localparam int MINP = 4;
  localparam int D = 8;
  logic clk = 0, rst_n = 0, ext_ctrl = 0, ext_step = 0, ext_dir = 0;
  logic cmd_valid = 0, cmd_dir = 0, abort = 0, clear_pos = 0;
  logic [CNT_W-1:0] cmd_steps = '0, cmd_period = '0;
  logic cmd_ready, step_strobe, busy, done, aborted;
  logic [POS_W-1:0] step_pos, pos = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  step_move_controller #(.POS_W(POS_W), .CNT_W(CNT_W), .MIN_PERIOD(MINP), .DWELL_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .ext_ctrl(ext_ctrl), .ext_step(ext_step), .ext_dir(ext_dir),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .abort(abort), .clear_pos(clear_pos), .step_pos(step_pos),
    .step_strobe(step_strobe), .busy(busy), .done(done), .aborted(aborted)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input logic st, input logic bz, input logic dn, input logic ab, input logic rdy);
    chk({tag, "_pos"}, step_pos, pos);
    chk({tag, "_strobe"}, 32'(step_strobe), 32'(st));
    chk({tag, "_busy"}, 32'(busy), 32'(bz));
    chk({tag, "_done"}, 32'(done), 32'(dn));
    chk({tag, "_aborted"}, 32'(aborted), 32'(ab));
    chk({tag, "_ready"}, 32'(cmd_ready), 32'(rdy));
  endtask
  task automatic move(input logic dir, input int n, input int p, input int abort_at, input bit by_ext);
    int pe, end_j, k;
    bit cut;
    logic [31:0] start;
    pe = p < MINP ? MINP : p;
    start = pos;
    end_j = abort_at > 0 ? abort_at : n * pe + D;
    chk("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_dir = dir; cmd_steps = CNT_W'(n); cmd_period = CNT_W'(p);
    tick;
    cmd_valid = 0;
    if (n == 0) begin
      outs("zero", 0, 0, 1, 0, 1);
      tick;
      outs("zero_after", 0, 0, 0, 0, 1);
      return;
    end
    for (int j = 0; j <= end_j; j++) begin
      cut = abort_at > 0 && j == abort_at;
      k = (cut ? j - 1 : j) / pe;
      if (k > n) k = n;
      pos = dir ? start - 32'(k) : start + 32'(k);
      outs("move", !cut && j > 0 && j % pe == 0 && j / pe <= n, j < end_j, j == end_j, cut, j == end_j && !ext_ctrl);
      if (j < end_j) begin
        if (j + 1 == abort_at) begin
          if (by_ext) ext_ctrl = 1; else abort = 1;
        end
        tick;
      end
    end
    abort = 0; ext_ctrl = 0;
    tick;
    outs("idle_after", 0, 0, 0, 0, 1);
  endtask
  task automatic ext_pulse(input logic dir, input bit clr);
    ext_step = 1; ext_dir = dir;
    tick; outs("ext_s1", 0, 0, 0, 0, !ext_ctrl);
    tick; outs("ext_s2", 0, 0, 0, 0, !ext_ctrl);
    clear_pos = clr;
    tick;
    clear_pos = 0;
    pos = clr ? '0 : !ext_ctrl ? pos : dir ? pos - 32'd1 : pos + 32'd1;
    outs("ext_upd", !clr && ext_ctrl, 0, 0, 0, !ext_ctrl);
    ext_step = 0;
    repeat (3) begin
      tick; outs("ext_low", 0, 0, 0, 0, !ext_ctrl);
    end
  endtask
  initial begin
    int n, p, pe, ab;
    #1 outs("reset", 0, 0, 0, 0, 1);
    tick; tick;
    rst_n = 1;
    tick; outs("post_reset", 0, 0, 0, 0, 1);
    cmd_valid = 1; cmd_dir = 0; cmd_steps = 16'd10; cmd_period = 16'd5;
    tick;
    cmd_valid = 0;
    repeat (12) tick;
    pos = 32'd2;
    outs("midrun", 0, 1, 0, 0, 0);
    #2 rst_n = 0;
    #1 pos = '0;
    outs("in_reset", 0, 0, 0, 0, 1);
    rst_n = 1;
    repeat (4) begin
      tick; outs("after_reset", 0, 0, 0, 0, 1);
    end
    move(0, 5, 10, 0, 0);
    move(0, 3, 1, 0, 0);
    move(0, 0, 7, 0, 0);
    clear_pos = 1; tick; clear_pos = 0; pos = '0;
    outs("clear", 0, 0, 0, 0, 1);
    move(1, 2, 5, 0, 0);
    chk("wrap_pos", step_pos, 32'hFFFF_FFFE);
    move(0, 6, 5, 14, 0);
    move(1, 6, 5, 14, 1);
    clear_pos = 1; tick; clear_pos = 0; pos = '0;
    outs("clear2", 0, 0, 0, 0, 1);
    ext_ctrl = 1; cmd_valid = 1; cmd_steps = 16'd3; cmd_period = 16'd4;
    tick; outs("ext_on", 0, 0, 0, 0, 0);
    repeat (4) ext_pulse(0, 0);
    repeat (2) ext_pulse(1, 0);
    chk("ext_pos2", step_pos, 32'd2);
    ext_pulse(0, 1);
    for (int i = 0; i < 6; i++) ext_pulse(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
    cmd_valid = 0;
    tick;
    ext_ctrl = 0;
    tick; outs("ext_off", 0, 0, 0, 0, 1);
    ext_pulse(0, 0);
    for (int i = 0; i < 8; i++) begin
      n = int'($urandom_range(0, 6));
      p = int'($urandom_range(0, 9));
      pe = p < MINP ? MINP : p;
      ab = (n > 0 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * pe + D)) : 0;
      move(1'($urandom_range(0, 1)), n, p, ab, 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
